// File: rtl/traffic_light_if.sv
// Lamp/pedestrian bus between the traffic-light controller and the top level.
interface traffic_light_if;
    logic       ped_req;
    logic       night;
    logic       red;
    logic       yellow;
    logic       green;
    logic       ped_walk;
    logic [2:0] phase;

    // Board side: drives the requests, observes the lamps.
    modport master (
        output ped_req, night,
        input  red, yellow, green, ped_walk, phase
    );

    // Controller side.
    modport slave (
        input  ped_req, night,
        output red, yellow, green, ped_walk, phase
    );
endinterface

// File: rtl/traffic_light_ctrl.sv
// Single-approach traffic-light phase controller (Moore machine).
// Sequence RED -> RED_YELLOW -> GREEN -> GREEN_BLINK -> YELLOW -> RED with
// per-phase cycle counts; a latched pedestrian request shortens GREEN.
// Optional night blink mode is enabled by defining NIGHT_MODE_EN.
module traffic_light_ctrl #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned T_RED       = 8,
    parameter int unsigned T_RY        = 2,
    parameter int unsigned T_GREEN     = 8,
    parameter int unsigned T_MIN_GREEN = 3,
    parameter int unsigned T_GBLINK    = 4,
    parameter int unsigned T_YELLOW    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    traffic_light_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_RED         = 3'd0,
        ST_RED_YELLOW  = 3'd1,
        ST_GREEN       = 3'd2,
        ST_GREEN_BLINK = 3'd3,
        ST_YELLOW      = 3'd4,
        ST_NIGHT       = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] RED_LAST   = CNT_W'(T_RED - 1);
    localparam logic [CNT_W-1:0] RY_LAST    = CNT_W'(T_RY - 1);
    localparam logic [CNT_W-1:0] GREEN_LAST = CNT_W'(T_GREEN - 1);
    localparam logic [CNT_W-1:0] MING_LAST  = CNT_W'(T_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(T_GBLINK - 1);
    localparam logic [CNT_W-1:0] YEL_LAST   = CNT_W'(T_YELLOW - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             ped_pending, ped_nx;

`ifdef NIGHT_MODE_EN
    localparam logic [CNT_W-1:0] NIGHT_LAST = CNT_W'(2 * T_YELLOW - 1);
    localparam logic [CNT_W:0]   NIGHT_HALF = (CNT_W + 1)'(T_YELLOW);
    logic night_req;
    assign night_req = bus.night;
`else
    // night input has no function in this build.
    logic unused_night;
    assign unused_night = bus.night;
`endif

    // State, phase counter and pedestrian latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RED;
            cnt         <= '0;
            ped_pending <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            ped_pending <= ped_nx;
        end
    end

    // Next state, counter and pedestrian latch update.
    always_comb begin
        logic   phase_end;
        state_t succ;
        state_nx  = state;
        cnt_nx    = cnt + CNT_W'(1);
        ped_nx    = ped_pending;
        phase_end = 1'b0;
        succ      = ST_RED;

        case (state)
            ST_RED: begin
                succ      = ST_RED_YELLOW;
                phase_end = (cnt == RED_LAST);
            end
            ST_RED_YELLOW: begin
                succ      = ST_GREEN;
                phase_end = (cnt == RY_LAST);
            end
            ST_GREEN: begin
                succ      = ST_GREEN_BLINK;
                phase_end = (cnt == GREEN_LAST) || (ped_pending && (cnt >= MING_LAST));
            end
            ST_GREEN_BLINK: begin
                succ      = ST_YELLOW;
                phase_end = (cnt == BLINK_LAST);
            end
            ST_YELLOW: begin
                succ      = ST_RED;
                phase_end = (cnt == YEL_LAST);
            end
`ifdef NIGHT_MODE_EN
            ST_NIGHT: begin
                // Blink period wraps; leave only at a period end with night released.
                if (cnt == NIGHT_LAST) begin
                    cnt_nx = '0;
                    if (!night_req) state_nx = ST_RED;
                end
            end
`endif
            default: begin
                state_nx = ST_RED;
                cnt_nx   = '0;
            end
        endcase

        if (phase_end) begin
            cnt_nx   = '0;
            state_nx = succ;
`ifdef NIGHT_MODE_EN
            if (night_req) state_nx = ST_NIGHT;
`endif
        end

        // Clearing on entry to RED/NIGHT wins over a same-cycle request.
        if ((state_nx == ST_RED) || (state_nx == ST_NIGHT)) begin
            ped_nx = 1'b0;
        end else if (bus.ped_req && (state != ST_RED) && (state != ST_NIGHT)) begin
            ped_nx = 1'b1;
        end
    end

    // Lamp decode from state and counter only.
    always_comb begin
        bus.red      = 1'b0;
        bus.yellow   = 1'b0;
        bus.green    = 1'b0;
        bus.ped_walk = 1'b0;
        bus.phase    = 3'(state);
        case (state)
            ST_RED: begin
                bus.red      = 1'b1;
                bus.ped_walk = 1'b1;
            end
            ST_RED_YELLOW: begin
                bus.red    = 1'b1;
                bus.yellow = 1'b1;
            end
            ST_GREEN:       bus.green  = 1'b1;
            ST_GREEN_BLINK: bus.green  = ~cnt[0];
            ST_YELLOW:      bus.yellow = 1'b1;
`ifdef NIGHT_MODE_EN
            ST_NIGHT:       bus.yellow = ({1'b0, cnt} < NIGHT_HALF);
`endif
            default: ;
        endcase
    end

endmodule

// File: doc/traffic_light_ctrl.md
# traffic_light_ctrl

Phase controller for a single-approach traffic light with two yellow phases (red+yellow before green, yellow after green). It sequences RED → RED_YELLOW → GREEN → GREEN_BLINK → YELLOW → RED with per-phase cycle counts and drives the lamp outputs directly as a Moore machine. It latches a pedestrian request that shortens green. It sits between the board clock/reset and the lamp/LED pins of the traffic-light top level.

## Interface
- `CNT_W`, 8, width of the phase cycle counter
- `T_RED`, 8, cycles spent in RED
- `T_RY`, 2, cycles spent in RED_YELLOW
- `T_GREEN`, 8, maximum cycles spent in GREEN
- `T_MIN_GREEN`, 3, minimum cycles in GREEN before a pedestrian request may cut it short
- `T_GBLINK`, 4, cycles spent in GREEN_BLINK
- `T_YELLOW`, 2, cycles spent in YELLOW; also the half-period of the night blink
- `clk` input 1: single clock, rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `ped_req` input 1: pedestrian button, sampled every cycle, level or pulse
- `night` input 1: night-mode request; used only with `NIGHT_MODE_EN`
- `red` output 1: red lamp
- `yellow` output 1: yellow lamp
- `green` output 1: green lamp
- `ped_walk` output 1: pedestrian "walk" lamp
- `phase` output 3: current state code. RED=0, RED_YELLOW=1, GREEN=2, GREEN_BLINK=3, YELLOW=4, NIGHT=5.

## Operation
- The design has three registers: the state, `cnt` (CNT_W bits), and `ped_pending`. All are reset asynchronously. Reset values: state=RED, cnt=0, ped_pending=0.
- Phase length rule:
  - In state S, if cnt == T_S−1, the next state is the successor and cnt becomes 0.
  - Otherwise cnt increments.
  - Each phase therefore lasts exactly T_S cycles. One full cycle is 24 clocks with the default parameters.
- Transitions:
  - RED → RED_YELLOW
  - RED_YELLOW → GREEN
  - GREEN → GREEN_BLINK
  - GREEN_BLINK → YELLOW
  - YELLOW → RED
  - Undefined state codes go to RED with cnt=0.
- Early green exit: in GREEN, if ped_pending=1 and cnt ≥ T_MIN_GREEN−1, the next state is GREEN_BLINK with cnt=0.
- ped_pending behaviour:
  - Set by ped_req=1 in any state except RED.
  - Cleared on the cycle the state enters RED, and clearing takes priority over setting.
  - ped_req while in RED is ignored.
- Outputs are combinational from the state and cnt only, with no input-to-output path:
  - red = 1 in RED and RED_YELLOW.
  - yellow = 1 in RED_YELLOW and YELLOW.
  - green = 1 in GREEN. In GREEN_BLINK, green = ~cnt[0], so it is on during even counts.
  - ped_walk = 1 in RED only.
  - All lamps are 0 in undefined states.
- Reset values of the outputs: red=1, yellow=0, green=0, ped_walk=1, phase=0.
- Parameter constraints: every T_* is ≥ 1 and ≤ 2^CNT_W, and T_MIN_GREEN ≤ T_GREEN. cnt never wraps because the phase end always reloads it to 0.

## Timing
- The state and cnt update on the rising edge of `clk`. Outputs change in the same cycle as the state, with no extra latency.
- ped_req sampled at edge k sets ped_pending at edge k.
  - If GREEN is active and cnt ≥ T_MIN_GREEN−1 after edge k, GREEN_BLINK is entered at edge k+1.
  - A request arriving before T_MIN_GREEN−1 holds until cnt reaches T_MIN_GREEN−1.
- Simultaneous events:
  - A pedestrian cut on the natural last GREEN cycle produces the same transition. ped_pending stays set until RED.
  - ped_req on the edge that enters RED is dropped.
- Reset mid-phase: when rst_n falls, the controller goes to RED immediately, without waiting for a clock. When rst_n is released, counting resumes from cnt=0 on the first edge.

## Configuration
- Macro: `NIGHT_MODE_EN`.
- With the macro defined:
  - night=1 sampled on the last cycle of any phase sends the next state to NIGHT, with cnt=0, instead of the successor.
  - In NIGHT, cnt counts 0..2·T_YELLOW−1 and wraps. yellow = (cnt < T_YELLOW), and all other lamps are 0.
  - NIGHT exits to RED with cnt=0 when night=0 on the cycle cnt == 2·T_YELLOW−1.
  - ped_req is ignored in NIGHT, and ped_pending is cleared on entering NIGHT.
- Without the macro: the night input is unused, NIGHT is unreachable, and code 5 is treated as undefined (goes to RED).

## Test plan
- Reset, then 48 idle clocks. Required response:
  - phase sequence 0×8, 1×2, 2×8, 3×4, 4×2, repeated twice.
  - lamps as specified.
  - green pattern 1,0,1,0 during GREEN_BLINK.
- One-cycle ped_req during GREEN at cnt=0 → GREEN lasts exactly 3 cycles, then GREEN_BLINK; ped_walk=1 for all 8 RED cycles that follow.
- ped_req held during RED → no effect; the next GREEN lasts the full 8 cycles.
- rst_n pulsed low during GREEN at cnt=5 → outputs go to red=1, ped_walk=1, phase=0 before the next clock edge; RED then lasts 8 cycles after release.
- With `NIGHT_MODE_EN`:
  - night=1 raised in GREEN → enters NIGHT after GREEN ends, with yellow 1,1,0,0 repeating.
  - night dropped → RED is entered at the next period end (cnt=3).
- Without `NIGHT_MODE_EN`: night=1 held → the normal 24-cycle sequence is unchanged.
